// File: rtl/param_torus_relax_mesh.sv
// rtl/param_torus_relax_mesh.sv - toroidal ROWS x COLS mesh that iterates max/min relaxation to a fixed point
// Holds the grid in registers and reports a per-cell local-extremum map.
module param_torus_relax_mesh #(
  parameter int ROWS     = 18,
  parameter int COLS     = 26,
  parameter int W        = 2,
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [ROWS*COLS*W-1:0] load_data,
  input  logic                   mode_min,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [ITER_W-1:0]      iter_count,
  output logic [ROWS*COLS*W-1:0] grid_out,
  output logic [ROWS*COLS-1:0]   peak_map
);

  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t              state_q;
  logic [N*W-1:0]      grid_q;
  logic [N*W-1:0]      nxt_d;
  logic [N-1:0]        peak_q;
  logic [N-1:0]        peak_d;
  logic                mode_q;
  logic                busy_q;
  logic                done_q;
  logic                timeout_q;
  logic [ITER_W-1:0]   iter_q;
  logic [ITER_W-1:0]   iter_inc_d;

  function automatic logic [W-1:0] pick(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic mn);
    if (mn) return (b < a) ? b : a;
    else    return (b > a) ? b : a;
  endfunction

  // One relaxation step and the extremum flag for every cell, all with torus wrap.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int J  = r * COLS + c;
      localparam int JN = (J - COLS + N) % N;
      localparam int JS = (J + COLS) % N;
      localparam int JW = r * COLS + (c - 1 + COLS) % COLS;
      localparam int JE = r * COLS + (c + 1) % COLS;

      logic [W-1:0] self_v, n_v, s_v, w_v, e_v;

      assign self_v = grid_q[J*W +: W];
      assign n_v    = grid_q[JN*W +: W];
      assign s_v    = grid_q[JS*W +: W];
      assign w_v    = grid_q[JW*W +: W];
      assign e_v    = grid_q[JE*W +: W];

      assign nxt_d[J*W +: W] = pick(pick(pick(pick(self_v, n_v, mode_q), s_v, mode_q),
                                         w_v, mode_q), e_v, mode_q);
      assign peak_d[J] = mode_q ? ((self_v <= n_v) && (self_v <= s_v) &&
                                   (self_v <= w_v) && (self_v <= e_v))
                                : ((self_v >= n_v) && (self_v >= s_v) &&
                                   (self_v >= w_v) && (self_v >= e_v));
    end
  end

  assign iter_inc_d = iter_q + ITER_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grid_q    <= '0;
      peak_q    <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      iter_q    <= '0;
    end else begin
      peak_q <= peak_d;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (load_valid) begin
            grid_q <= load_data;
          end else if (start) begin
            mode_q    <= mode_min;
            iter_q    <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          // Convergence wins over the iteration limit when both would apply.
          if (nxt_d == grid_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            grid_q <= nxt_d;
            iter_q <= iter_inc_d;
            if (iter_inc_d == ITER_W'(MAX_ITER)) begin
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_FIN;
            end
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign load_ready = (state_q == S_IDLE);
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign iter_count = iter_q;
  assign grid_out   = grid_q;
  assign peak_map   = peak_q;

endmodule

// File: tb/tb_param_torus_relax_mesh.sv
// tb/tb_param_torus_relax_mesh.sv - scoreboard bench for param_torus_relax_mesh on a 3x4 torus
// Two instances share stimulus: one with the default iteration limit, one with a limit of 2.
module tb_param_torus_relax_mesh;

  localparam int R = 3;
  localparam int C = 4;
  localparam int NC = R * C;

  typedef struct {
    logic [23:0] g;
    int          it;
    bit          to;
    logic [11:0] pk;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [23:0] load_data = '0;
  logic        mode_min = 1'b0;
  logic        start = 1'b0;

  logic        load_ready_a, busy_a, done_a, timeout_a;
  logic [7:0]  iter_a;
  logic [23:0] grid_a;
  logic [11:0] peak_a;
  logic        load_ready_b, busy_b, done_b, timeout_b;
  logic [7:0]  iter_b;
  logic [23:0] grid_b;
  logic [11:0] peak_b;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   cur_mode = 1'b0;
  exp_t qa[$];
  exp_t qb[$];

  param_torus_relax_mesh #(.ROWS(R), .COLS(C), .W(2), .MAX_ITER(255), .ITER_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_a),
    .load_data(load_data), .mode_min(mode_min), .start(start), .busy(busy_a),
    .done(done_a), .timeout(timeout_a), .iter_count(iter_a), .grid_out(grid_a),
    .peak_map(peak_a)
  );

  param_torus_relax_mesh #(.ROWS(R), .COLS(C), .W(2), .MAX_ITER(2), .ITER_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready_b),
    .load_data(load_data), .mode_min(mode_min), .start(start), .busy(busy_b),
    .done(done_b), .timeout(timeout_b), .iter_count(iter_b), .grid_out(grid_b),
    .peak_map(peak_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int nbr(input int j, input int k);
    int r, c;
    r = j / C;
    c = j % C;
    case (k)
      0:       return (j - C + NC) % NC;
      1:       return (j + C) % NC;
      2:       return r * C + (c - 1 + C) % C;
      default: return r * C + (c + 1) % C;
    endcase
  endfunction

  function automatic logic [23:0] step(input logic [23:0] g, input bit mn);
    logic [23:0] o;
    logic [1:0]  v, u;
    o = g;
    for (int j = 0; j < NC; j++) begin
      v = g[2*j +: 2];
      for (int k = 0; k < 4; k++) begin
        u = g[2*nbr(j, k) +: 2];
        if (mn ? (u < v) : (u > v)) v = u;
      end
      o[2*j +: 2] = v;
    end
    return o;
  endfunction

  function automatic logic [11:0] peaks(input logic [23:0] g, input bit mn);
    logic [11:0] p;
    logic [1:0]  v, u;
    for (int j = 0; j < NC; j++) begin
      v = g[2*j +: 2];
      p[j] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        u = g[2*nbr(j, k) +: 2];
        if (mn ? (v > u) : (v < u)) p[j] = 1'b0;
      end
    end
    return p;
  endfunction

  function automatic exp_t model(input logic [23:0] g0, input bit mn, input int lim, input int e0);
    exp_t        e;
    logic [23:0] n;
    e.g  = g0;
    e.it = 0;
    e.to = 1'b0;
    for (int guard = 0; guard < 1000; guard++) begin
      n = step(e.g, mn);
      if (n == e.g) break;
      e.g = n;
      e.it++;
      if (e.it == lim) begin
        e.to = 1'b1;
        break;
      end
    end
    e.pk  = peaks(e.g, mn);
    e.cyc = e.to ? e0 + e.it : e0 + e.it + 1;
    return e;
  endfunction

  task automatic check_done(input string tag, input exp_t e, input logic [23:0] g,
                            input logic [7:0] it, input logic to, input logic [11:0] pk,
                            input logic bz);
    chk({tag, "_grid"}, g, e.g);
    chk({tag, "_iter"}, it, e.it);
    chk({tag, "_timeout"}, to, e.to);
    chk({tag, "_done_cycle"}, cyc, e.cyc);
    chk({tag, "_busy_on_done"}, bz, 1'b0);
    if (!e.to) chk({tag, "_peak"}, pk, e.pk);
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) chk("a_unexpected_done", done_a, 1'b0);
      else check_done("a", qa.pop_front(), grid_a, iter_a, timeout_a, peak_a, busy_a);
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (qb.size() == 0) chk("b_unexpected_done", done_b, 1'b0);
      else check_done("b", qb.pop_front(), grid_b, iter_b, timeout_b, peak_b, busy_b);
    end
  end

  task automatic issue(input logic [23:0] g, input bit mn);
    int e0;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = g;
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
    chk("load_grid", grid_a, g);
    chk("load_peak", peak_a, peaks(g, cur_mode));
    start    = 1'b1;
    mode_min = mn;
    @(posedge clk);
    #1;
    e0       = cyc;
    start    = 1'b0;
    cur_mode = mn;
    qa.push_back(model(g, mn, 255, e0));
    qb.push_back(model(g, mn, 2, e0));
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      chk("done_wait_expired", 1'b1, 1'b0);
      qa.delete();
      qb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [23:0] g;
    repeat (2) @(negedge clk);
    chk("rst_grid", grid_a, 24'h0);
    chk("rst_iter", iter_a, 8'h0);
    chk("rst_peak", peak_a, 12'h0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_timeout", timeout_a, 1'b0);
    chk("rst_load_ready", load_ready_a, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // single peak spreading under max relaxation, with and without the iteration limit
    issue(24'h3, 1'b0);
    drain();
    chk("t1_iter_a", iter_a, 8'd3);
    chk("t1_peak_a", peak_a, 12'hFFF);
    chk("t1_timeout_b", timeout_b, 1'b1);
    chk("t1_iter_b", iter_b, 8'd2);
    chk("t1_cell6_b", grid_b[12 +: 2], 2'd0);
    chk("t1_cell10_b", grid_b[20 +: 2], 2'd0);
    chk("t1_cell1_b", grid_b[2 +: 2], 2'd3);

    // single valley under min relaxation
    g = 24'hFFFFFF;
    g[10 +: 2] = 2'd0;
    issue(g, 1'b1);
    drain();
    chk("t3_grid_a", grid_a, 24'h0);
    chk("t3_iter_a", iter_a, 8'd3);

    // uniform grid converges on the first check
    issue(24'hAAAAAA, 1'b0);
    drain();
    chk("t4_iter_a", iter_a, 8'd0);
    chk("t4_peak_a", peak_a, 12'hFFF);

    // row wrap: cell 3 reaches cell 0 but not cell 4
    g = '0;
    g[6 +: 2] = 2'd2;
    issue(g, 1'b0);
    @(negedge clk);
    @(negedge clk);
    g[0 +: 2]  = 2'd2;
    g[4 +: 2]  = 2'd2;
    g[14 +: 2] = 2'd2;
    g[22 +: 2] = 2'd2;
    chk("wrap_grid_a", grid_a, g);
    chk("wrap_cell4_a", grid_a[8 +: 2], 2'd0);
    drain();

    // asynchronous reset in the second RUN cycle aborts without done
    issue(24'h3, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    chk("abort_grid", grid_a, 24'h0);
    chk("abort_iter", iter_a, 8'h0);
    chk("abort_busy", busy_a, 1'b0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    cur_mode = 1'b0;
    repeat (4) @(negedge clk);

    // load and start together: load wins, no run
    @(negedge clk);
    load_valid = 1'b1;
    start      = 1'b1;
    load_data  = 24'h00C30F;
    @(negedge clk);
    load_valid = 1'b0;
    start      = 1'b0;
    chk("ls_grid", grid_a, 24'h00C30F);
    chk("ls_busy", busy_a, 1'b0);
    chk("ls_ready", load_ready_a, 1'b1);
    repeat (3) @(negedge clk);
    chk("ls_busy_later", busy_a, 1'b0);

    for (int n = 0; n < 30; n++) begin
      g = 24'($urandom);
      if (n % 3 == 0) g = g & 24'($urandom) & 24'($urandom);
      issue(g, 1'($urandom_range(0, 1)));
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
